// File: rtl/mips_multicycle_core.sv
// Multi-cycle MIPS32 core: a single memory port shared by fetch and load/store,
// a five-state control FSM and an internal 32x32 register file.
module mips_multicycle_core #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter bit          ENABLE_JAL = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] mem_addr,
    output logic        mem_re,
    output logic        mem_we,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    output logic [31:0] pc_o,
    output logic [2:0]  state_o,
    output logic        retire_o,
    output logic        illegal_o
);
    localparam int unsigned XLEN = 32;
    localparam int unsigned NREG = 32;
    localparam int unsigned RIDX = 5;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4
    } state_e;

    state_e            state_q, state_d;
    logic [XLEN-1:0]   pc_q, pc_d, ir_q, ir_d, a_q, a_d, b_q, b_d;
    logic [XLEN-1:0]   alu_q, alu_d, mdr_q, mdr_d;
    logic              retire_q, retire_d, illegal_q, illegal_d;
    logic [XLEN-1:0]   rf_q [NREG];
    logic              rf_we;
    logic [RIDX-1:0]   rf_waddr;
    logic [XLEN-1:0]   rf_wdata;

    // Instruction fields and decode
    logic [5:0]      opcode, funct;
    logic [RIDX-1:0] rs, rt, rd, shamt;
    logic [15:0]     imm16;
    logic [25:0]     imm26;
    logic [XLEN-1:0] sext_imm, rs_val, rt_val, alu_r, jump_tgt;
    logic            is_alu_r, is_jr, is_addi, is_lw, is_sw, is_beq, is_j, is_jal, is_legal;

    assign opcode   = ir_q[31:26];
    assign rs       = ir_q[25:21];
    assign rt       = ir_q[20:16];
    assign rd       = ir_q[15:11];
    assign shamt    = ir_q[10:6];
    assign funct    = ir_q[5:0];
    assign imm16    = ir_q[15:0];
    assign imm26    = ir_q[25:0];
    assign sext_imm = {{16{imm16[15]}}, imm16};
    assign jump_tgt = {pc_q[31:28], imm26, 2'b00};
    assign rs_val   = (rs == '0) ? '0 : rf_q[rs];
    assign rt_val   = (rt == '0) ? '0 : rf_q[rt];

    assign is_alu_r = (opcode == 6'h00) &&
                      (funct == 6'h20 || funct == 6'h22 || funct == 6'h24 ||
                       funct == 6'h25 || funct == 6'h2A || funct == 6'h00);
    assign is_jr    = (opcode == 6'h00) && (funct == 6'h08);
    assign is_addi  = (opcode == 6'h08);
    assign is_lw    = (opcode == 6'h23);
    assign is_sw    = (opcode == 6'h2B);
    assign is_beq   = (opcode == 6'h04);
    assign is_j     = (opcode == 6'h02);
    assign is_jal   = ENABLE_JAL && (opcode == 6'h03);
    assign is_legal = is_alu_r | is_jr | is_addi | is_lw | is_sw | is_beq | is_j | is_jal;

    // R-type ALU result from the latched operands
    always_comb begin
        alu_r = '0;
        case (funct)
            6'h20:   alu_r = a_q + b_q;
            6'h22:   alu_r = a_q - b_q;
            6'h24:   alu_r = a_q & b_q;
            6'h25:   alu_r = a_q | b_q;
            6'h2A:   alu_r = {{(XLEN-1){1'b0}}, ($signed(a_q) < $signed(b_q))};
            6'h00:   alu_r = b_q << shamt;
            default: alu_r = '0;
        endcase
    end

    // Control FSM next state, datapath next values and memory request
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        a_d       = a_q;
        b_d       = b_q;
        alu_d     = alu_q;
        mdr_d     = mdr_q;
        retire_d  = 1'b0;
        illegal_d = 1'b0;
        rf_we     = 1'b0;
        rf_waddr  = '0;
        rf_wdata  = '0;
        mem_addr  = '0;
        mem_re    = 1'b0;
        mem_we    = 1'b0;
        mem_wdata = '0;
        case (state_q)
            S_FETCH: begin
                mem_re   = 1'b1;
                mem_addr = {pc_q[31:2], 2'b00};
                if (mem_ready) begin
                    ir_d    = mem_rdata;
                    pc_d    = pc_q + XLEN'(4);
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                a_d     = rs_val;
                b_d     = rt_val;
                alu_d   = pc_q + {sext_imm[29:0], 2'b00};
                state_d = S_FETCH;
                if (!is_legal) begin
                    illegal_d = 1'b1;
                end else if (is_j || is_jal) begin
                    pc_d     = jump_tgt;
                    retire_d = 1'b1;
                    if (is_jal) begin
                        rf_we    = 1'b1;
                        rf_waddr = RIDX'(31);
                        rf_wdata = pc_q;
                    end
                end else if (is_jr) begin
                    pc_d     = rs_val;
                    retire_d = 1'b1;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                state_d = S_FETCH;
                if (is_alu_r) begin
                    alu_d   = alu_r;
                    state_d = S_WB;
                end else if (is_addi) begin
                    alu_d   = a_q + sext_imm;
                    state_d = S_WB;
                end else if (is_lw || is_sw) begin
                    alu_d   = a_q + sext_imm;
                    state_d = S_MEM;
                end else begin
                    if (a_q == b_q) pc_d = alu_q;
                    retire_d = 1'b1;
                end
            end
            S_MEM: begin
                mem_addr = {alu_q[31:2], 2'b00};
                if (is_lw) begin
                    mem_re = 1'b1;
                end else begin
                    mem_we    = 1'b1;
                    mem_wdata = b_q;
                end
                if (mem_ready) begin
                    if (is_lw) begin
                        mdr_d   = mem_rdata;
                        state_d = S_WB;
                    end else begin
                        retire_d = 1'b1;
                        state_d  = S_FETCH;
                    end
                end
            end
            S_WB: begin
                rf_we    = 1'b1;
                rf_waddr = (is_lw || is_addi) ? rt : rd;
                rf_wdata = is_lw ? mdr_q : alu_q;
                retire_d = 1'b1;
                state_d  = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_FETCH;
            pc_q      <= RESET_PC;
            ir_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            alu_q     <= '0;
            mdr_q     <= '0;
            retire_q  <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            a_q       <= a_d;
            b_q       <= b_d;
            alu_q     <= alu_d;
            mdr_q     <= mdr_d;
            retire_q  <= retire_d;
            illegal_q <= illegal_d;
        end
    end

    // Register file; entry 0 is never written
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < NREG; i++) rf_q[i] <= '0;
        end else if (rf_we && (rf_waddr != '0)) begin
            rf_q[rf_waddr] <= rf_wdata;
        end
    end

    assign pc_o      = pc_q;
    assign state_o   = state_q;
    assign retire_o  = retire_q;
    assign illegal_o = illegal_q;
endmodule

// File: tb/tb_mips_multicycle_core.sv
// Self-checking bench for mips_multicycle_core: unified memory model with
// programmable wait states, retire/illegal/store scoreboards per scenario.
module tb_mips_multicycle_core;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] mem_addr, mem_wdata, mem_rdata, pc_o;
    logic        mem_re, mem_we, mem_ready, retire_o, illegal_o;
    logic [2:0]  state_o;

    mips_multicycle_core #(.RESET_PC(32'h0000_0100), .ENABLE_JAL(1'b1)) dut (
        .clk(clk), .reset(reset),
        .mem_addr(mem_addr), .mem_re(mem_re), .mem_we(mem_we),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .pc_o(pc_o), .state_o(state_o), .retire_o(retire_o), .illegal_o(illegal_o)
    );

    always #5 clk = ~clk;

    // Memory model: 256 words, ready after stall_cfg wait cycles per request
    logic [31:0] mem [0:255];
    int          stall_cfg = 0;
    int          wait_cnt = 0;
    logic        clr = 1'b0, ld_en = 1'b0;
    logic [31:0] ld_a = '0, ld_d = '0;

    assign mem_ready = (wait_cnt >= stall_cfg);
    assign mem_rdata = mem[mem_addr[9:2]];

    always @(posedge clk) begin
        if (reset) wait_cnt <= 0;
        else if ((mem_re || mem_we) && !mem_ready) wait_cnt <= wait_cnt + 1;
        else wait_cnt <= 0;
        if (clr) begin
            for (int i = 0; i < 256; i++) mem[i] <= '0;
        end else if (ld_en) begin
            mem[ld_a[9:2]] <= ld_d;
        end else if (mem_we && mem_ready) begin
            mem[mem_addr[9:2]] <= mem_wdata;
        end
    end

    int vectors = 0, miscompares = 0, cyc = 0;
    int          exp_ret[$];
    int          exp_ill[$];
    logic [31:0] exp_sa[$], exp_sd[$];
    logic        exp_r, exp_i;
    logic [31:0] ea, ed;

    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction
    function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [4:0] sh,
                                          input logic [5:0] fn);
        return {6'h00, rs, rt, rd, sh, fn};
    endfunction
    function automatic logic [31:0] enc_j(input logic [5:0] op, input logic [31:0] tgt);
        return {op, tgt[27:2]};
    endfunction

    task automatic tick();
        @(posedge clk); #1;
        cyc++;
    endtask
    task automatic poke(input logic [31:0] a, input logic [31:0] d);
        ld_en = 1'b1; ld_a = a; ld_d = d;
        @(posedge clk); #1;
        ld_en = 1'b0;
    endtask
    task automatic hold_reset(input int stall);
        reset = 1'b1; stall_cfg = stall;
        exp_ret.delete(); exp_ill.delete(); exp_sa.delete(); exp_sd.delete();
        @(posedge clk); #1;
        clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
    endtask
    task automatic release_reset();
        @(posedge clk); #1;
        reset = 1'b0;
        cyc = 0;
    endtask

    task automatic test_reset();
        hold_reset(0);
        release_reset();
        vectors++; if (pc_o !== 32'h100) begin miscompares++; $display("FAIL reset_pc: got %h want %h", pc_o, 32'h100); end
        vectors++; if (state_o !== 3'd0) begin miscompares++; $display("FAIL reset_state: got %0d want 0", state_o); end
        vectors++; if ({retire_o, illegal_o, mem_we} !== 3'b000) begin miscompares++; $display("FAIL reset_pulses: got %b want 000", {retire_o, illegal_o, mem_we}); end
        vectors++; if (mem_re !== 1'b1 || mem_addr !== 32'h100) begin miscompares++; $display("FAIL first_fetch: re %b addr %h want 1 00000100", mem_re, mem_addr); end
        tick();
        vectors++; if (pc_o !== 32'h104 || state_o !== 3'd1) begin miscompares++; $display("FAIL after_fetch: pc %h st %0d want 00000104 1", pc_o, state_o); end
        for (int n = 2; n <= 5; n++) begin
            tick();
            vectors++; if (retire_o !== (cyc == 4)) begin miscompares++; $display("FAIL nop_retire: cycle %0d got %b", cyc, retire_o); end
        end
    endtask

    task automatic test_arith_mem();
        logic [31:0] prog [20];
        int          lat  [20];
        int          rc;
        prog = '{enc_i(6'h08, 0, 1, 16'd5),  enc_i(6'h08, 0, 2, 16'd7),  enc_r(1, 2, 3, 0, 6'h20),
                 enc_i(6'h2B, 0, 3, 16'd0),  enc_i(6'h23, 0, 4, 16'd0),  enc_i(6'h2B, 0, 4, 16'd4),
                 enc_r(1, 2, 5, 0, 6'h22),   enc_r(5, 1, 6, 0, 6'h2A),   enc_r(0, 2, 7, 3, 6'h00),
                 enc_r(3, 2, 8, 0, 6'h24),   enc_r(3, 2, 9, 0, 6'h25),   enc_i(6'h2B, 0, 5, 16'd8),
                 enc_i(6'h2B, 0, 6, 16'd12), enc_i(6'h2B, 0, 7, 16'd16), enc_i(6'h2B, 0, 8, 16'd20),
                 enc_i(6'h2B, 0, 9, 16'd24), enc_i(6'h08, 0, 0, 16'd9),  enc_i(6'h2B, 0, 0, 16'd28),
                 enc_i(6'h04, 1, 2, 16'd100), enc_i(6'h2B, 0, 1, 16'd32)};
        lat  = '{4, 4, 4, 4, 5, 4, 4, 4, 4, 4, 4, 4, 4, 4, 4, 4, 4, 4, 3, 4};
        hold_reset(0);
        rc = 0;
        for (int k = 0; k < 20; k++) begin
            poke(32'h100 + 32'(4 * k), prog[k]);
            rc += lat[k];
            exp_ret.push_back(rc);
        end
        exp_sa = '{32'd0, 32'd4, 32'd8, 32'd12, 32'd16, 32'd20, 32'd24, 32'd28, 32'd32};
        exp_sd = '{32'd12, 32'd12, 32'hFFFF_FFFE, 32'd1, 32'd56, 32'd4, 32'd15, 32'd0, 32'd5};
        release_reset();
        for (int n = 1; n <= 82; n++) begin
            tick();
            exp_r = 1'b0;
            if (exp_ret.size() != 0) if (exp_ret[0] == cyc) begin exp_r = 1'b1; void'(exp_ret.pop_front()); end
            vectors++; if (retire_o !== exp_r) begin miscompares++; $display("FAIL arith_retire: cycle %0d got %b want %b", cyc, retire_o, exp_r); end
            if (mem_we && mem_ready) begin
                vectors++;
                if (exp_sa.size() == 0) begin miscompares++; $display("FAIL arith_store: unexpected store %h<=%h at cycle %0d", mem_addr, mem_wdata, cyc); end
                else begin
                    ea = exp_sa.pop_front(); ed = exp_sd.pop_front();
                    if (mem_addr !== ea || mem_wdata !== ed) begin miscompares++; $display("FAIL arith_store: got %h<=%h want %h<=%h", mem_addr, mem_wdata, ea, ed); end
                end
            end
            if (mem_re && mem_we) begin vectors++; miscompares++; $display("FAIL arith_re_we: both asserted at cycle %0d", cyc); end
        end
        vectors++; if (exp_sa.size() != 0 || exp_ret.size() != 0) begin miscompares++; $display("FAIL arith_pending: stores %0d retires %0d left, want 0", exp_sa.size(), exp_ret.size()); end
    endtask

    task automatic test_beq_loop();
        hold_reset(0);
        poke(32'h100, enc_j(6'h02, 32'h20));
        poke(32'h020, enc_i(6'h04, 0, 0, 16'hFFFF));
        exp_ret = '{2, 5, 8, 11};
        release_reset();
        for (int n = 1; n <= 12; n++) begin
            tick();
            exp_r = 1'b0;
            if (exp_ret.size() != 0) if (exp_ret[0] == cyc) begin exp_r = 1'b1; void'(exp_ret.pop_front()); end
            vectors++; if (retire_o !== exp_r) begin miscompares++; $display("FAIL beq_retire: cycle %0d got %b want %b", cyc, retire_o, exp_r); end
            if (mem_we) begin vectors++; miscompares++; $display("FAIL beq_store: write at cycle %0d", cyc); end
            if (cyc == 11) begin
                vectors++; if (pc_o !== 32'h20 || state_o !== 3'd0) begin miscompares++; $display("FAIL beq_target: pc %h st %0d want 00000020 0", pc_o, state_o); end
            end
        end
        reset = 1'b1;
        tick();
        vectors++; if (pc_o !== 32'h100 || state_o !== 3'd0 || retire_o !== 1'b0) begin miscompares++; $display("FAIL beq_reset: pc %h st %0d ret %b want 00000100 0 0", pc_o, state_o, retire_o); end
    endtask

    task automatic test_jal_jr();
        hold_reset(0);
        poke(32'h100, enc_j(6'h02, 32'h40));
        poke(32'h040, enc_j(6'h03, 32'h80));
        poke(32'h080, enc_r(31, 0, 0, 0, 6'h08));
        poke(32'h044, enc_i(6'h2B, 0, 31, 16'd36));
        exp_ret = '{2, 4, 6, 10};
        exp_sa = '{32'd36};
        exp_sd = '{32'h44};
        release_reset();
        for (int n = 1; n <= 11; n++) begin
            tick();
            exp_r = 1'b0;
            if (exp_ret.size() != 0) if (exp_ret[0] == cyc) begin exp_r = 1'b1; void'(exp_ret.pop_front()); end
            vectors++; if (retire_o !== exp_r) begin miscompares++; $display("FAIL jal_retire: cycle %0d got %b want %b", cyc, retire_o, exp_r); end
            if (cyc == 4) begin vectors++; if (pc_o !== 32'h80) begin miscompares++; $display("FAIL jal_pc: got %h want 00000080", pc_o); end end
            if (cyc == 6) begin vectors++; if (pc_o !== 32'h44) begin miscompares++; $display("FAIL jr_pc: got %h want 00000044", pc_o); end end
            if (mem_we && mem_ready) begin
                vectors++;
                if (exp_sa.size() == 0) begin miscompares++; $display("FAIL jal_store: unexpected store %h<=%h", mem_addr, mem_wdata); end
                else begin
                    ea = exp_sa.pop_front(); ed = exp_sd.pop_front();
                    if (mem_addr !== ea || mem_wdata !== ed) begin miscompares++; $display("FAIL jal_store: got %h<=%h want %h<=%h", mem_addr, mem_wdata, ea, ed); end
                end
            end
        end
        vectors++; if (exp_sa.size() != 0) begin miscompares++; $display("FAIL jal_pending: %0d stores missing, want 0", exp_sa.size()); end
    endtask

    task automatic test_stall();
        logic        p_pend, p_re, p_we;
        logic [31:0] p_addr, p_wd;
        hold_reset(3);
        poke(32'h000, 32'hDEAD_BEEF);
        poke(32'h100, enc_i(6'h23, 0, 4, 16'd0));
        poke(32'h104, enc_i(6'h2B, 0, 4, 16'd4));
        poke(32'h108, enc_i(6'h2B, 0, 4, 16'd8));
        exp_ret = '{11, 21};
        exp_sa = '{32'd4};
        exp_sd = '{32'hDEAD_BEEF};
        release_reset();
        p_pend = (mem_re || mem_we) && !mem_ready;
        p_re = mem_re; p_we = mem_we; p_addr = mem_addr; p_wd = mem_wdata;
        for (int n = 1; n <= 28; n++) begin
            tick();
            exp_r = 1'b0;
            if (exp_ret.size() != 0) if (exp_ret[0] == cyc) begin exp_r = 1'b1; void'(exp_ret.pop_front()); end
            vectors++; if (retire_o !== exp_r) begin miscompares++; $display("FAIL stall_retire: cycle %0d got %b want %b", cyc, retire_o, exp_r); end
            if (p_pend) begin
                vectors++;
                if (mem_re !== p_re || mem_we !== p_we || mem_addr !== p_addr || (p_we && mem_wdata !== p_wd)) begin
                    miscompares++; $display("FAIL stall_stable: cycle %0d re/we/addr %b%b %h was %b%b %h", cyc, mem_re, mem_we, mem_addr, p_re, p_we, p_addr);
                end
            end
            if (cyc <= 11) begin vectors++; if (mem_we !== 1'b0) begin miscompares++; $display("FAIL stall_lw_we: cycle %0d got %b want 0", cyc, mem_we); end end
            if (mem_we && mem_ready) begin
                vectors++;
                if (exp_sa.size() == 0) begin miscompares++; $display("FAIL stall_store: unexpected store %h<=%h at cycle %0d", mem_addr, mem_wdata, cyc); end
                else begin
                    ea = exp_sa.pop_front(); ed = exp_sd.pop_front();
                    if (mem_addr !== ea || mem_wdata !== ed) begin miscompares++; $display("FAIL stall_store: got %h<=%h want %h<=%h", mem_addr, mem_wdata, ea, ed); end
                end
            end
            p_pend = (mem_re || mem_we) && !mem_ready;
            p_re = mem_re; p_we = mem_we; p_addr = mem_addr; p_wd = mem_wdata;
        end
        vectors++; if (mem_we !== 1'b1 || mem_ready !== 1'b0 || mem_addr !== 32'h8) begin miscompares++; $display("FAIL stall_mem_wait: we %b rdy %b addr %h want 1 0 00000008", mem_we, mem_ready, mem_addr); end
        reset = 1'b1;
        tick();
        vectors++; if (mem_we !== 1'b0 || state_o !== 3'd0 || pc_o !== 32'h100 || retire_o !== 1'b0) begin
            miscompares++; $display("FAIL stall_abort: we %b st %0d pc %h ret %b want 0 0 00000100 0", mem_we, state_o, pc_o, retire_o);
        end
        vectors++; if (mem[2] !== 32'h0 || exp_sa.size() != 0) begin miscompares++; $display("FAIL stall_abort_mem: word8 %h pending %0d want 0 0", mem[2], exp_sa.size()); end
    endtask

    task automatic test_illegal();
        hold_reset(0);
        poke(32'h100, 32'hFC21_0005);
        poke(32'h104, enc_i(6'h2B, 0, 1, 16'd40));
        poke(32'h108, enc_r(0, 0, 2, 0, 6'h3F));
        poke(32'h10C, enc_i(6'h2B, 0, 2, 16'd44));
        exp_ret = '{6, 12};
        exp_ill = '{2, 8};
        exp_sa = '{32'd40, 32'd44};
        exp_sd = '{32'd0, 32'd0};
        release_reset();
        for (int n = 1; n <= 13; n++) begin
            tick();
            exp_r = 1'b0; exp_i = 1'b0;
            if (exp_ret.size() != 0) if (exp_ret[0] == cyc) begin exp_r = 1'b1; void'(exp_ret.pop_front()); end
            if (exp_ill.size() != 0) if (exp_ill[0] == cyc) begin exp_i = 1'b1; void'(exp_ill.pop_front()); end
            vectors++; if (retire_o !== exp_r) begin miscompares++; $display("FAIL ill_retire: cycle %0d got %b want %b", cyc, retire_o, exp_r); end
            vectors++; if (illegal_o !== exp_i) begin miscompares++; $display("FAIL ill_pulse: cycle %0d got %b want %b", cyc, illegal_o, exp_i); end
            if (cyc == 2) begin vectors++; if (pc_o !== 32'h104 || state_o !== 3'd0) begin miscompares++; $display("FAIL ill_pc: pc %h st %0d want 00000104 0", pc_o, state_o); end end
            if (mem_we && mem_ready) begin
                vectors++;
                if (exp_sa.size() == 0) begin miscompares++; $display("FAIL ill_store: unexpected store %h<=%h", mem_addr, mem_wdata); end
                else begin
                    ea = exp_sa.pop_front(); ed = exp_sd.pop_front();
                    if (mem_addr !== ea || mem_wdata !== ed) begin miscompares++; $display("FAIL ill_store: got %h<=%h want %h<=%h", mem_addr, mem_wdata, ea, ed); end
                end
            end
        end
        vectors++; if (exp_sa.size() != 0) begin miscompares++; $display("FAIL ill_pending: %0d stores missing, want 0", exp_sa.size()); end
    endtask

    initial begin
        test_reset();
        test_arith_mem();
        test_beq_loop();
        test_jal_jr();
        test_stall();
        test_illegal();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
